// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub
//   Digit-serial two's-complement adder/subtractor. A start request latches
//   the operands, then one DIGIT-wide slice is added per clock, LSB digit
//   first, through a single DIGIT-wide adder. After N = WIDTH/DIGIT RUN
//   cycles the full result and its flags are published together.
//
// Handshake: start is sampled on a rising clk edge while the block is not
//   busy (IDLE or DONE). busy is high for exactly the N cycles of RUN.
//   done is a one-cycle pulse in the DONE state, during which sum, carryout,
//   overflow and zero are valid. These outputs then hold until the next
//   completion. A start seen while busy is dropped, not queued.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                request a new operation
//   op_sub               0 = A + B, 1 = A - B (sampled with start)
//   accumulate           1 = use current sum in place of a (sampled with start)
//   a, b                 WIDTH-bit two's-complement operands
//   busy, done           status (RUN / DONE)
//   sum                  registered WIDTH-bit result
//   carryout             carry out of the MSB (subtract: 1 = no borrow)
//   overflow             signed overflow
//   zero                 sum == 0
//   dbg_state            current FSM state (0 IDLE, 1 RUN, 2 DONE)
module digit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  // Digit datapath
  logic [DIGIT-1:0]       dsum;
  logic                   dcarry;
  logic                   msb_cin;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;
  logic                   last_digit;

  always_comb begin
    {dcarry, dsum} = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of this digit, recovered from the sum bit.
    // On the final digit this is the carry into the MSB of the word.
    msb_cin    = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ dsum[DIGIT-1];
    // New digit enters at the top; after N steps the word is aligned.
    res_cat    = {dsum, res_q} >> DIGIT;
    res_next   = res_cat[WIDTH-1:0];
    last_digit = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_d      = res_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // In DONE, sum_q already holds the just-completed result.
          opa_d   = accumulate ? sum_q : a;
          opb_d   = op_sub ? ~b : b;
          carry_d = op_sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = dcarry;
        res_d   = res_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          sum_d      = res_next;
          carryout_d = dcarry;
          overflow_d = msb_cin ^ dcarry;
          zero_d     = (res_next == '0);
          cnt_d      = '0;
          state_d    = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule
